car_update_scheduler: RTL

Per-frame game-state sequencer for the RoadFighter design. On each frame tick it walks one shared add/compare datapath through the player record and the five enemy car records, one record per cycle. For each record it updates speed, steering and vertical scroll, and it detects player/enemy collisions. Its registered outputs feed `graphic_controller`, and it is the sole owner of the car position registers.

---
 rtl/car_update_scheduler_if.sv | 25 ++
 rtl/car_update_scheduler.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/car_update_scheduler_if.sv
// Frame-tick handshake, player controls and game-state outputs shared
// between the RoadFighter sequencer and its environment.
interface car_update_scheduler_if;
  logic        frame_tick;
  logic        game_en;
  logic        btn_left;
  logic        btn_right;
  logic        btn_accel;
  logic [7:0]  player_x;
  logic [2:0]  speed;
  logic [39:0] car_y;
  logic        crash;
  logic        busy;
  logic        upd_done;

  modport master (
    output frame_tick, game_en, btn_left, btn_right, btn_accel,
    input  player_x, speed, car_y, crash, busy, upd_done
  );

  modport slave (
    input  frame_tick, game_en, btn_left, btn_right, btn_accel,
    output player_x, speed, car_y, crash, busy, upd_done
  );
endinterface

// File: rtl/car_update_scheduler.sv
// Per-frame sequencer: one shared add/compare step per cycle, walking the
// player record then the five enemy cars, with sticky collision detection.
module car_update_scheduler #(
  parameter int ROAD_LEFT  = 40,
  parameter int ROAD_RIGHT = 200,
  parameter int PLAYER_Y   = 200,
  parameter int CAR_W      = 16,
  parameter int CAR_H      = 24,
  parameter int STEER      = 2,
  parameter int MAX_SPEED  = 7,
  parameter int Y_WRAP     = 240,
  parameter int LANE_BASE  = 56,
  parameter int LANE_STEP  = 28
) (
  input  logic                 clk,
  input  logic                 reset,
  car_update_scheduler_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PLAYER = 2'd1;
  localparam logic [1:0] S_CAR    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] MAX_S    = 4'(MAX_SPEED);
  localparam logic [8:0] LEFT9    = 9'(ROAD_LEFT);
  localparam logic [8:0] RIGHT9   = 9'(ROAD_RIGHT);
  localparam logic [8:0] STEER9   = 9'(STEER);
  localparam logic [8:0] WRAP9    = 9'(Y_WRAP);
  localparam logic [8:0] PY9      = 9'(PLAYER_Y);
  localparam logic [8:0] CW9      = 9'(CAR_W);
  localparam logic [8:0] CH9      = 9'(CAR_H);
  localparam logic [7:0] PX_INIT  = 8'((ROAD_LEFT + ROAD_RIGHT) / 2);
  localparam logic [4:0][7:0] Y_INIT = {8'd192, 8'd144, 8'd96, 8'd48, 8'd0};

  logic [1:0]      state_q, state_d;
  logic [2:0]      k_q, k_d;
  logic            left_q, left_d, right_q, right_d, accel_q, accel_d;
  logic [7:0]      px_q, px_d;
  logic [2:0]      spd_q, spd_d;
  logic [2:0]      step_q, step_d;
  logic [4:0][7:0] cary_q, cary_d;
  logic            crash_q, crash_d;
  logic            busy_q, upd_done_q;

  logic [3:0]        spd_inc_s;
  logic [8:0]        px_sum_s;
  logic [2:0]        idx_s;
  logic [8:0]        y_sum_s, y_new_s, lane_s;
  logic signed [8:0] dx_s, dy_s;
  logic [8:0]        adx_s, ady_s;

  // Next-state logic for the sequencer and the shared datapath
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    left_d    = left_q;
    right_d   = right_q;
    accel_d   = accel_q;
    px_d      = px_q;
    spd_d     = spd_q;
    step_d    = step_q;
    cary_d    = cary_q;
    crash_d   = crash_q;
    spd_inc_s = {1'b0, spd_q} + 4'd1;
    px_sum_s  = {1'b0, px_q} + STEER9;
    idx_s     = k_q - 3'd1;
    y_sum_s   = {1'b0, cary_q[idx_s]} + {6'd0, step_q};
    y_new_s   = (y_sum_s >= WRAP9) ? (y_sum_s - WRAP9) : y_sum_s;
    lane_s    = 9'(LANE_BASE) + 9'(idx_s) * 9'(LANE_STEP);
    dx_s      = $signed(lane_s) - $signed({1'b0, px_q});
    dy_s      = $signed(y_new_s) - $signed(PY9);
    adx_s     = dx_s[8] ? 9'(-dx_s) : 9'(dx_s);
    ady_s     = dy_s[8] ? 9'(-dy_s) : 9'(dy_s);
    case (state_q)
      S_IDLE: begin
        if (bus.frame_tick && bus.game_en && !crash_q) begin
          state_d = S_PLAYER;
          left_d  = bus.btn_left;
          right_d = bus.btn_right;
          accel_d = bus.btn_accel;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PLAYER: begin
        if (accel_q) begin
          spd_d = (spd_inc_s > MAX_S) ? MAX_S[2:0] : spd_inc_s[2:0];
        end else begin
          spd_d = (spd_q == 3'd0) ? 3'd0 : spd_q - 3'd1;
        end
        // Compare before subtracting so the left clamp never goes negative
        if (left_q && !right_q) begin
          px_d = ({1'b0, px_q} < LEFT9 + STEER9) ? LEFT9[7:0] : px_q - STEER9[7:0];
        end else if (right_q && !left_q) begin
          px_d = (px_sum_s > RIGHT9) ? RIGHT9[7:0] : px_sum_s[7:0];
        end else begin
          px_d = px_q;
        end
        step_d  = spd_d;
        k_d     = 3'd1;
        state_d = S_CAR;
      end
      S_CAR: begin
        cary_d[idx_s] = y_new_s[7:0];
        if ((adx_s < CW9) && (ady_s < CH9)) begin
          crash_d = 1'b1;
          spd_d   = 3'd0;
        end else begin
          crash_d = crash_q;
        end
        if (k_q == 3'd5) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; busy and upd_done trail the state by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      k_q        <= 3'd1;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      accel_q    <= 1'b0;
      px_q       <= PX_INIT;
      spd_q      <= 3'd0;
      step_q     <= 3'd0;
      cary_q     <= Y_INIT;
      crash_q    <= 1'b0;
      busy_q     <= 1'b0;
      upd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      left_q     <= left_d;
      right_q    <= right_d;
      accel_q    <= accel_d;
      px_q       <= px_d;
      spd_q      <= spd_d;
      step_q     <= step_d;
      cary_q     <= cary_d;
      crash_q    <= crash_d;
      busy_q     <= (state_d != S_IDLE) || (state_q == S_DONE);
      upd_done_q <= (state_q == S_DONE);
    end
  end

  assign bus.player_x = px_q;
  assign bus.speed    = spd_q;
  assign bus.car_y    = cary_q;
  assign bus.crash    = crash_q;
  assign bus.busy     = busy_q;
  assign bus.upd_done = upd_done_q;

endmodule
